// File: rtl/uart_tx_baud.sv
// uart_tx_baud: async-serial transmitter timed by rising edges of a divided baud clock.
// Frames are start, LSB-first data, optional parity, then 1 or 2 stop bits.
module uart_tx_baud #(
    parameter int         DATA_BITS    = 8,
    parameter bit         PARITY_EN    = 1'b0,
    parameter bit         PARITY_ODD   = 1'b0,
    parameter logic [1:0] STOP_BITS    = 2'd1,
    parameter int         BIT_CNT_SIZE = $clog2(DATA_BITS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_clk,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t                  r_state, w_state_nxt;
    logic                    r_baud_q;
    logic [DATA_BITS-1:0]    r_shift, w_shift_nxt;
    logic [BIT_CNT_SIZE-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic                    r_stop_cnt, w_stop_cnt_nxt;
    logic                    r_par, w_par_nxt;
    logic                    r_tx, w_tx_nxt;
    logic                    r_done, w_done_nxt;
    logic                    w_tick, w_accept, w_bit_last, w_stop_last;
    assign w_tick      = baud_clk & ~r_baud_q;
    assign w_accept    = tx_valid & tx_ready;
    assign w_bit_last  = r_bit_cnt == BIT_CNT_SIZE'(DATA_BITS - 1);
    assign w_stop_last = r_stop_cnt == 1'(STOP_BITS - 2'd1);
    // baud_q resets high so a baud_clk already high at release is not an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_q   <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_q   <= baud_clk;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_par      <= w_par_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
        end
    end
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_par_nxt      = r_par;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_shift_nxt = tx_data;
                w_par_nxt   = PARITY_ODD ? ~^tx_data : ^tx_data;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: if (w_tick) begin
                w_tx_nxt    = 1'b0;
                w_state_nxt = S_START;
            end
            S_START: if (w_tick) begin
                w_tx_nxt      = r_shift[0];
                w_shift_nxt   = r_shift >> 1;
                w_bit_cnt_nxt = '0;
                w_state_nxt   = S_DATA;
            end
            S_DATA: if (w_tick) begin
                if (!w_bit_last) begin
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end else if (PARITY_EN) begin
                    w_tx_nxt    = r_par;
                    w_state_nxt = S_PARITY;
                end else begin
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = S_STOP;
                end
            end
            S_PARITY: if (w_tick) begin
                w_tx_nxt       = 1'b1;
                w_stop_cnt_nxt = 1'b0;
                w_state_nxt    = S_STOP;
            end
            S_STOP: if (w_tick) begin
                w_stop_cnt_nxt = w_stop_last ? r_stop_cnt : r_stop_cnt + 1'b1;
                w_state_nxt    = w_stop_last ? S_IDLE : S_STOP;
                w_done_nxt     = w_stop_last;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
    always_comb begin
        tx_ready = r_state == S_IDLE;
        tx       = r_tx;
        tx_done  = r_done;
    end
endmodule
